// File: rtl/game_pkg.sv
// Shared types and constants for the memory-match turn controller.
package game_pkg;

  localparam int NUM_CARDS_DEF = 36;
  localparam int VAL_W_DEF     = 6;
  // The cursor and read address are 6 bits wide, so any index lies in 0..63.
  localparam int CARD_SLOTS    = 64;

  typedef logic [5:0]           card_idx_t;
  typedef logic [VAL_W_DEF-1:0] card_val_t;

  typedef enum logic [2:0] {
    ST_PICK1   = 3'd0,
    ST_READ1   = 3'd1,
    ST_PICK2   = 3'd2,
    ST_READ2   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_HOLD    = 3'd5,
    ST_DONE    = 3'd6
  } game_state_t;

endpackage

// File: rtl/match_game_ctrl_hold_timer.sv
// Mismatch display timer: load starts a countdown of HOLD_CYCLES cycles.
// o_done is high during the last of those cycles.
module hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_load,
  output logic o_done
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CNT_W-1:0] r_count;
  logic             r_active;

  assign o_done = r_active && (r_count == '0);

  // Countdown register; goes idle after the final cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_count  <= CNT_W'(HOLD_CYCLES - 1);
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/match_game_ctrl.sv
// Turn controller for the memory-match game. It takes two card picks, reads
// both values and compares them. A match marks the pair permanently. A mismatch
// keeps both cards face-up for a hold interval and then flips them back.
module match_game_ctrl
  import game_pkg::*;
#(
  parameter int NUM_CARDS   = NUM_CARDS_DEF,
  parameter int VAL_W       = 6,
  parameter int MEM_LAT     = 1,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 btn_a,
  input  logic [5:0]           cursor,
  output logic [5:0]           mem_raddr,
  input  logic [VAL_W-1:0]     mem_rdata,
  output logic [NUM_CARDS-1:0] face_up,
  output logic [NUM_CARDS-1:0] matched,
  output logic [4:0]           pair_count,
  output logic                 busy,
  output logic                 match_pulse,
  output logic                 mismatch_pulse,
  output logic                 game_over
);

  localparam int         LAT_W       = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [4:0] PAIRS_TOTAL = 5'(NUM_CARDS / 2);

  game_state_t          r_state;
  game_state_t          w_state_next;
  card_idx_t            r_sel1;
  card_idx_t            r_sel2;
  card_idx_t            r_mem_raddr;
  logic [VAL_W-1:0]     r_val1;
  logic [VAL_W-1:0]     r_val2;
  logic [LAT_W-1:0]     r_lat_cnt;
  logic [NUM_CARDS-1:0] r_face_up;
  logic [NUM_CARDS-1:0] r_matched;
  logic [4:0]           r_pair_count;
  logic                 r_match_pulse;
  logic                 r_mismatch_pulse;

  logic [NUM_CARDS-1:0]  w_cur_oh;
  logic [NUM_CARDS-1:0]  w_sel1_oh;
  logic [NUM_CARDS-1:0]  w_sel2_oh;
  logic [CARD_SLOTS-1:0] w_matched_pad;
  logic                  w_in_range;
  logic                  w_press_ok;
  logic                  w_read_done;
  logic                  w_vals_equal;
  logic [4:0]            w_pair_inc;
  logic                  w_last_pair;
  logic                  w_hold_load;
  logic                  w_hold_done;

  // One-hot decodes of the cursor and of both selections.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CARDS; gi++) begin : g_card
      assign w_cur_oh[gi]  = (cursor == card_idx_t'(gi));
      assign w_sel1_oh[gi] = (r_sel1 == card_idx_t'(gi));
      assign w_sel2_oh[gi] = (r_sel2 == card_idx_t'(gi));
    end
  endgenerate

  // Padding lets the matched lookup be indexed by any cursor value without
  // going outside the vector. The range check below decides validity.
  assign w_matched_pad = CARD_SLOTS'(r_matched);
  assign w_in_range    = (32'(cursor) < NUM_CARDS);
  assign w_press_ok    = btn_a && w_in_range && !w_matched_pad[cursor] &&
                         ((r_state == ST_PICK1) ||
                          ((r_state == ST_PICK2) && (cursor != r_sel1)));

  assign w_read_done  = (r_lat_cnt == LAT_W'(MEM_LAT));
  assign w_vals_equal = (r_val1 == r_val2);
  assign w_pair_inc   = (r_pair_count < PAIRS_TOTAL) ? r_pair_count + 5'd1 : r_pair_count;
  assign w_last_pair  = (w_pair_inc == PAIRS_TOTAL);

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_hold_load),
    .o_done  (w_hold_done)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_PICK1;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. Presses count only in the two pick states.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PICK1:   if (w_press_ok)  w_state_next = ST_READ1;
      ST_READ1:   if (w_read_done) w_state_next = ST_PICK2;
      ST_PICK2:   if (w_press_ok)  w_state_next = ST_READ2;
      ST_READ2:   if (w_read_done) w_state_next = ST_COMPARE;
      ST_COMPARE: w_state_next = w_vals_equal ? (w_last_pair ? ST_DONE : ST_PICK1) : ST_HOLD;
      ST_HOLD:    if (w_hold_done) w_state_next = ST_PICK1;
      ST_DONE:    w_state_next = ST_DONE;
      default:    w_state_next = ST_PICK1;
    endcase
  end

  // State-decoded outputs and the hold timer load.
  always_comb begin
    busy        = 1'b1;
    game_over   = 1'b0;
    w_hold_load = 1'b0;
    case (r_state)
      ST_PICK1, ST_PICK2: busy = 1'b0;
      ST_COMPARE:         w_hold_load = !w_vals_equal;
      ST_DONE:            game_over = 1'b1;
      default:            ;
    endcase
  end

  // Selection, read capture, card bitmaps, pair count and result strobes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sel1           <= '0;
      r_sel2           <= '0;
      r_mem_raddr      <= '0;
      r_val1           <= '0;
      r_val2           <= '0;
      r_lat_cnt        <= '0;
      r_face_up        <= '0;
      r_matched        <= '0;
      r_pair_count     <= '0;
      r_match_pulse    <= 1'b0;
      r_mismatch_pulse <= 1'b0;
    end else begin
      r_match_pulse    <= 1'b0;
      r_mismatch_pulse <= 1'b0;
      case (r_state)
        ST_PICK1: begin
          if (w_press_ok) begin
            r_sel1      <= cursor;
            r_mem_raddr <= cursor;
            r_face_up   <= r_face_up | w_cur_oh;
            r_lat_cnt   <= '0;
          end
        end
        ST_READ1: begin
          if (w_read_done) begin
            r_val1 <= mem_rdata;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        ST_PICK2: begin
          if (w_press_ok) begin
            r_sel2      <= cursor;
            r_mem_raddr <= cursor;
            r_face_up   <= r_face_up | w_cur_oh;
            r_lat_cnt   <= '0;
          end
        end
        ST_READ2: begin
          if (w_read_done) begin
            r_val2 <= mem_rdata;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        ST_COMPARE: begin
          if (w_vals_equal) begin
            r_matched     <= r_matched | w_sel1_oh | w_sel2_oh;
            r_pair_count  <= w_pair_inc;
            r_match_pulse <= 1'b1;
          end else begin
            r_mismatch_pulse <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_hold_done) begin
            r_face_up <= (r_face_up & ~(w_sel1_oh | w_sel2_oh)) | r_matched;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_raddr      = r_mem_raddr;
  assign face_up        = r_face_up;
  assign matched        = r_matched;
  assign pair_count     = r_pair_count;
  assign match_pulse    = r_match_pulse;
  assign mismatch_pulse = r_mismatch_pulse;

endmodule

// File: tb/tb_match_game_ctrl.sv
// Directed bench for match_game_ctrl. Instance A uses MEM_LAT=1 and instance B
// uses MEM_LAT=2. Both use HOLD_CYCLES=8. The memory models return addr>>1.
module tb_match_game_ctrl;

  localparam int NC   = 36;
  localparam int VW   = 6;
  localparam int HOLD = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          a_reset_n, a_btn, a_busy, a_mp, a_mmp, a_go;
  logic [5:0]    a_cursor, a_raddr;
  logic [VW-1:0] a_rdata;
  logic [NC-1:0] a_face, a_matched;
  logic [4:0]    a_pairs;

  logic          b_reset_n, b_btn, b_busy, b_mp, b_mmp, b_go;
  logic [5:0]    b_cursor, b_raddr;
  logic [VW-1:0] b_rdata, b_pipe;
  logic [NC-1:0] b_face, b_matched;
  logic [4:0]    b_pairs;

  int n_checks = 0;
  int n_fail   = 0;

  match_game_ctrl #(.NUM_CARDS(NC), .VAL_W(VW), .MEM_LAT(1), .HOLD_CYCLES(HOLD)) dut_a (
    .clock(clock), .reset_n(a_reset_n), .btn_a(a_btn), .cursor(a_cursor),
    .mem_raddr(a_raddr), .mem_rdata(a_rdata), .face_up(a_face), .matched(a_matched),
    .pair_count(a_pairs), .busy(a_busy), .match_pulse(a_mp),
    .mismatch_pulse(a_mmp), .game_over(a_go)
  );

  match_game_ctrl #(.NUM_CARDS(NC), .VAL_W(VW), .MEM_LAT(2), .HOLD_CYCLES(HOLD)) dut_b (
    .clock(clock), .reset_n(b_reset_n), .btn_a(b_btn), .cursor(b_cursor),
    .mem_raddr(b_raddr), .mem_rdata(b_rdata), .face_up(b_face), .matched(b_matched),
    .pair_count(b_pairs), .busy(b_busy), .match_pulse(b_mp),
    .mismatch_pulse(b_mmp), .game_over(b_go)
  );

  // Card memories: value = address>>1, with one or two cycles of read latency.
  always @(posedge clock) a_rdata <= a_raddr >> 1;
  always @(posedge clock) begin
    b_pipe  <= b_raddr >> 1;
    b_rdata <= b_pipe;
  end

  function automatic logic [NC-1:0] cb(input int i);
    cb = '0;
    cb[i] = 1'b1;
  endfunction

  task automatic press(input bit sel_b, input logic [5:0] c);
    @(negedge clock);
    if (sel_b) begin b_btn = 1'b1; b_cursor = c; end
    else       begin a_btn = 1'b1; a_cursor = c; end
    @(negedge clock);
    a_btn = 1'b0;
    b_btn = 1'b0;
    $display("press dut=%s cursor=%0d", sel_b ? "B" : "A", c);
  endtask

  task automatic wait_idle(input bit sel_b, output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while ((sel_b ? b_busy : a_busy) && cycles < 40);
  endtask

  task automatic apply_reset(input bit sel_b);
    @(negedge clock);
    if (sel_b) b_reset_n = 1'b0; else a_reset_n = 1'b0;
    @(negedge clock);
    if (sel_b) b_reset_n = 1'b1; else a_reset_n = 1'b1;
    $display("reset dut=%s", sel_b ? "B" : "A");
  endtask

  task automatic test_reset;
    apply_reset(0);
    n_checks++; if (a_face !== '0) begin n_fail++; $display("FAIL reset_face_up: got %h want 0", a_face); end
    n_checks++; if (a_matched !== '0) begin n_fail++; $display("FAIL reset_matched: got %h want 0", a_matched); end
    n_checks++; if (a_pairs !== 5'd0) begin n_fail++; $display("FAIL reset_pair_count: got %0d want 0", a_pairs); end
    n_checks++; if ({a_busy, a_mp, a_mmp, a_go} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {a_busy, a_mp, a_mmp, a_go}); end
    n_checks++; if (a_raddr !== 6'd0) begin n_fail++; $display("FAIL reset_raddr: got %0d want 0", a_raddr); end
  endtask

  task automatic test_match;
    int cyc;
    press(0, 6'd4);
    n_checks++; if (a_raddr !== 6'd4) begin n_fail++; $display("FAIL match_raddr1: got %0d want 4", a_raddr); end
    n_checks++; if (a_face !== cb(4)) begin n_fail++; $display("FAIL match_face1: got %h want %h", a_face, cb(4)); end
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL match_busy_read1: got %b want 1", a_busy); end
    wait_idle(0, cyc);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL match_read1_cycles: got %0d want 2", cyc); end
    press(0, 6'd5);
    repeat (2) @(negedge clock);
    n_checks++; if (a_mp !== 1'b0) begin n_fail++; $display("FAIL match_pulse_early: got %b want 0", a_mp); end
    @(negedge clock);
    n_checks++; if (a_mp !== 1'b1) begin n_fail++; $display("FAIL match_pulse: got %b want 1", a_mp); end
    n_checks++; if (a_matched !== (cb(4) | cb(5))) begin n_fail++; $display("FAIL match_matched: got %h want %h", a_matched, cb(4) | cb(5)); end
    n_checks++; if (a_pairs !== 5'd1) begin n_fail++; $display("FAIL match_pair_count: got %0d want 1", a_pairs); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL match_back_to_pick1: busy got %b want 0", a_busy); end
    @(negedge clock);
    n_checks++; if (a_mp !== 1'b0) begin n_fail++; $display("FAIL match_pulse_width: got %b want 0", a_mp); end
  endtask

  task automatic test_mismatch;
    int cyc;
    bit hold_ok;
    press(0, 6'd0);
    wait_idle(0, cyc);
    press(0, 6'd2);
    repeat (3) @(negedge clock);
    n_checks++; if (a_mmp !== 1'b1) begin n_fail++; $display("FAIL mismatch_pulse: got %b want 1", a_mmp); end
    n_checks++; if (a_mp !== 1'b0) begin n_fail++; $display("FAIL mismatch_no_match_pulse: got %b want 0", a_mp); end
    n_checks++; if (a_face !== (cb(0) | cb(2) | cb(4) | cb(5))) begin n_fail++; $display("FAIL mismatch_face_hold1: got %h want %h", a_face, cb(0) | cb(2) | cb(4) | cb(5)); end
    hold_ok = 1'b1;
    for (int k = 2; k <= HOLD; k++) begin
      @(negedge clock);
      if (a_face[0] !== 1'b1 || a_face[2] !== 1'b1 || a_busy !== 1'b1) hold_ok = 1'b0;
    end
    n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL mismatch_hold_span: got %b want 1", hold_ok); end
    @(negedge clock);
    n_checks++; if (a_face !== (cb(4) | cb(5))) begin n_fail++; $display("FAIL mismatch_flip_back: got %h want %h", a_face, cb(4) | cb(5)); end
    n_checks++; if (a_matched !== (cb(4) | cb(5))) begin n_fail++; $display("FAIL mismatch_matched: got %h want %h", a_matched, cb(4) | cb(5)); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_end_busy: got %b want 0", a_busy); end
  endtask

  task automatic test_invalid;
    int cyc;
    press(0, 6'd40);
    n_checks++; if ({a_busy, a_raddr} !== {1'b0, 6'd2} || a_face !== (cb(4) | cb(5))) begin n_fail++; $display("FAIL invalid_range: busy=%b raddr=%0d face=%h want 0/2/%h", a_busy, a_raddr, a_face, cb(4) | cb(5)); end
    press(0, 6'd4);
    n_checks++; if ({a_busy, a_raddr} !== {1'b0, 6'd2} || a_face !== (cb(4) | cb(5))) begin n_fail++; $display("FAIL invalid_matched: busy=%b raddr=%0d face=%h want 0/2/%h", a_busy, a_raddr, a_face, cb(4) | cb(5)); end
    press(0, 6'd1);
    n_checks++; if ({a_busy, a_raddr} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL invalid_pick1_accept: busy=%b raddr=%0d want 1/1", a_busy, a_raddr); end
    press(0, 6'd3);   // lands in the last READ1 cycle
    n_checks++; if ({a_busy, a_raddr} !== {1'b0, 6'd1} || a_face !== (cb(1) | cb(4) | cb(5))) begin n_fail++; $display("FAIL invalid_during_read1: busy=%b raddr=%0d face=%h want 0/1/%h", a_busy, a_raddr, a_face, cb(1) | cb(4) | cb(5)); end
    press(0, 6'd1);
    n_checks++; if ({a_busy, a_raddr} !== {1'b0, 6'd1} || a_face !== (cb(1) | cb(4) | cb(5))) begin n_fail++; $display("FAIL invalid_sel1_again: busy=%b raddr=%0d face=%h want 0/1/%h", a_busy, a_raddr, a_face, cb(1) | cb(4) | cb(5)); end
    press(0, 6'd3);
    n_checks++; if (a_raddr !== 6'd3) begin n_fail++; $display("FAIL invalid_pick2_accept: got %0d want 3", a_raddr); end
    @(negedge clock);
    press(0, 6'd6);   // lands in COMPARE
    n_checks++; if (a_mmp !== 1'b1 || a_raddr !== 6'd3 || a_face !== (cb(1) | cb(3) | cb(4) | cb(5))) begin n_fail++; $display("FAIL invalid_during_compare: mmp=%b raddr=%0d face=%h want 1/3/%h", a_mmp, a_raddr, a_face, cb(1) | cb(3) | cb(4) | cb(5)); end
    press(0, 6'd7);   // lands in HOLD
    n_checks++; if (a_busy !== 1'b1 || a_raddr !== 6'd3 || a_face !== (cb(1) | cb(3) | cb(4) | cb(5))) begin n_fail++; $display("FAIL invalid_during_hold: busy=%b raddr=%0d face=%h want 1/3/%h", a_busy, a_raddr, a_face, cb(1) | cb(3) | cb(4) | cb(5)); end
    wait_idle(0, cyc);
    n_checks++; if (cyc != 6) begin n_fail++; $display("FAIL invalid_hold_remaining: got %0d want 6", cyc); end
    n_checks++; if (a_face !== (cb(4) | cb(5))) begin n_fail++; $display("FAIL invalid_hold_flip: got %h want %h", a_face, cb(4) | cb(5)); end
  endtask

  task automatic test_all_pairs;
    int cyc;
    int exp_pairs;
    exp_pairs = 1;
    for (int p = 0; p < NC / 2; p++) begin
      if (p == 2) continue;
      press(0, 6'(2 * p));
      wait_idle(0, cyc);
      press(0, 6'(2 * p + 1));
      repeat (3) @(negedge clock);
      exp_pairs++;
      n_checks++; if (a_mp !== 1'b1 || a_pairs !== 5'(exp_pairs)) begin n_fail++; $display("FAIL all_pairs_step%0d: pulse=%b count=%0d want 1/%0d", p, a_mp, a_pairs, exp_pairs); end
      if (p < NC / 2 - 1) begin
        n_checks++; if (a_go !== 1'b0) begin n_fail++; $display("FAIL all_pairs_early_over%0d: got %b want 0", p, a_go); end
      end
    end
    n_checks++; if ({a_go, a_busy} !== 2'b11) begin n_fail++; $display("FAIL done_flags: go/busy got %b want 11", {a_go, a_busy}); end
    n_checks++; if (a_pairs !== 5'd18) begin n_fail++; $display("FAIL done_pair_count: got %0d want 18", a_pairs); end
    n_checks++; if (a_matched !== {NC{1'b1}} || a_face !== {NC{1'b1}}) begin n_fail++; $display("FAIL done_bitmaps: matched=%h face=%h want all ones", a_matched, a_face); end
    press(0, 6'd0);
    press(0, 6'd1);
    repeat (3) @(negedge clock);
    n_checks++; if ({a_go, a_busy, a_mp} !== 3'b110 || a_pairs !== 5'd18) begin n_fail++; $display("FAIL done_ignores_press: go/busy/mp=%b count=%0d want 110/18", {a_go, a_busy, a_mp}, a_pairs); end
  endtask

  task automatic test_reset_mid_hold;
    int cyc;
    apply_reset(0);
    n_checks++; if ({a_go, a_pairs} !== 6'd0) begin n_fail++; $display("FAIL rst_from_done: go/count got %b/%0d want 0/0", a_go, a_pairs); end
    press(0, 6'd0);
    wait_idle(0, cyc);
    press(0, 6'd2);
    repeat (3) @(negedge clock);
    n_checks++; if (a_mmp !== 1'b1) begin n_fail++; $display("FAIL rst_enter_hold: got %b want 1", a_mmp); end
    repeat (2) @(negedge clock);
    a_reset_n = 1'b0;
    @(negedge clock);
    a_reset_n = 1'b1;
    $display("reset dut=A during hold cycle 3");
    n_checks++; if (a_face !== '0 || a_matched !== '0 || a_pairs !== 5'd0 || a_raddr !== 6'd0) begin n_fail++; $display("FAIL rst_hold_regs: face=%h matched=%h count=%0d raddr=%0d want all 0", a_face, a_matched, a_pairs, a_raddr); end
    n_checks++; if ({a_busy, a_mp, a_mmp, a_go} !== 4'b0000) begin n_fail++; $display("FAIL rst_hold_flags: got %b want 0000", {a_busy, a_mp, a_mmp, a_go}); end
    press(0, 6'd7);
    n_checks++; if (a_raddr !== 6'd7 || a_face !== cb(7) || a_busy !== 1'b1) begin n_fail++; $display("FAIL rst_new_press: raddr=%0d face=%h busy=%b want 7/%h/1", a_raddr, a_face, a_busy, cb(7)); end
  endtask

  task automatic test_mem_lat2;
    int cyc;
    apply_reset(1);
    press(1, 6'd4);
    n_checks++; if (b_raddr !== 6'd4) begin n_fail++; $display("FAIL lat2_raddr: got %0d want 4", b_raddr); end
    wait_idle(1, cyc);
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL lat2_read1_cycles: got %0d want 3", cyc); end
    press(1, 6'd5);
    repeat (3) @(negedge clock);
    n_checks++; if (b_mp !== 1'b0) begin n_fail++; $display("FAIL lat2_pulse_early: got %b want 0", b_mp); end
    @(negedge clock);
    n_checks++; if (b_mp !== 1'b1 || b_pairs !== 5'd1 || b_matched !== (cb(4) | cb(5))) begin n_fail++; $display("FAIL lat2_match: pulse=%b count=%0d matched=%h want 1/1/%h", b_mp, b_pairs, b_matched, cb(4) | cb(5)); end
    press(1, 6'd0);
    wait_idle(1, cyc);
    press(1, 6'd2);
    repeat (4) @(negedge clock);
    n_checks++; if (b_mmp !== 1'b1 || b_mp !== 1'b0) begin n_fail++; $display("FAIL lat2_mismatch: mmp=%b mp=%b want 1/0", b_mmp, b_mp); end
  endtask

  initial begin
    a_reset_n = 1'b0; a_btn = 1'b0; a_cursor = '0;
    b_reset_n = 1'b0; b_btn = 1'b0; b_cursor = '0;
    repeat (2) @(negedge clock);
    test_reset();
    test_match();
    test_mismatch();
    test_invalid();
    test_all_pairs();
    test_reset_mid_hold();
    test_mem_lat2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/match_game_ctrl.md
Name: match_game_ctrl

Overview:
Turn controller for the 6x6 memory-match game. Sequences two card selections from the cursor, reads each card value from the card memory (mem64 read port), and compares the two values. On a match it marks both cards matched; on a mismatch it holds both face-up for a display interval, then flips them back. Drives game_over when all pairs are found. Sits between the button/cursor logic and the VGA card renderer.

Parameters:
NUM_CARDS, 36, number of valid card slots (addresses 0..NUM_CARDS-1); must be even
VAL_W, 6, width of the card value word read from memory
MEM_LAT, 1, memory read latency in cycles from mem_raddr sampled to mem_rdata valid
HOLD_CYCLES, 50_000_000, mismatch display time in clock cycles (1 s at 50 MHz)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous, active-low reset
btn_a  in  1  select pulse, one cycle wide, debounced upstream
cursor  in  6  card index under the cursor
mem_raddr  out  6  registered read address to mem64
mem_rdata  in  VAL_W  card value from mem64
face_up  out  NUM_CARDS  bit i = card i rendered face-up (matched OR currently selected)
matched  out  NUM_CARDS  bit i = card i permanently paired
pair_count  out  5  number of pairs found, 0..NUM_CARDS/2
busy  out  1  high when not in PICK1/PICK2
match_pulse  out  1  one-cycle strobe on a successful compare
mismatch_pulse  out  1  one-cycle strobe on a failed compare
game_over  out  1  high once all pairs are matched

Behaviour:
- Reset (reset_n=0 at a rising edge): all outputs are 0, mem_raddr=0, state=PICK1, hold counter=0. Reset applied in any state, including mid-read and mid-hold, aborts the operation immediately.
- FSM states: PICK1, READ1, PICK2, READ2, COMPARE, HOLD, DONE.
- A press is valid only if cursor<NUM_CARDS, matched[cursor]=0, and, in PICK2, cursor!=sel1. Invalid presses, and presses in any other state, are ignored with no state change.
- PICK1, valid press: sel1<=cursor, mem_raddr<=cursor, face_up[cursor]<=1, go to READ1.
- READ1: wait, then capture val1<=mem_rdata on the (MEM_LAT+1)th rising edge after the accepting edge. Go to PICK2.
- PICK2, valid press: sel2<=cursor, mem_raddr<=cursor, face_up[cursor]<=1, go to READ2.
- READ2: capture val2 with the same timing as READ1, then go to COMPARE.
- COMPARE (exactly 1 cycle): compare the full VAL_W words.
  - On equality: set matched[sel1] and matched[sel2], increment pair_count, assert match_pulse on the next cycle. Go to DONE if the new pair_count equals NUM_CARDS/2, otherwise to PICK1.
  - On inequality: assert mismatch_pulse on the next cycle, load the hold counter, go to HOLD.
- HOLD: stay exactly HOLD_CYCLES cycles, then clear face_up[sel1] and face_up[sel2] (matched bits are untouched) and go to PICK1.
- DONE: game_over=1, busy=1, and all presses are ignored until reset.
- face_up always equals matched OR the selection bits of the current turn. It is registered and updates on the same edge as the state change.
- pair_count saturates at NUM_CARDS/2 and never wraps.
- A btn_a pulse coincident with a state-leaving edge is not carried into the next state; each state requires a fresh pulse.

Decomposition:
- Package game_pkg holds:
  - the state enum type
  - NUM_CARDS_DEF=36
  - typedef card_idx_t (logic [5:0])
  - typedef card_val_t (logic [VAL_W-1:0] default 6)
- One sub-module: hold_timer (load, count down, done strobe; width sized from HOLD_CYCLES).
- The FSM and the selection/matched registers stay in match_game_ctrl.

Test Plan:
- Bench conventions:
  - Memory model returns value addr>>1, so pairs are {0,1},{2,3},...
  - HOLD_CYCLES=8 for simulation.
  - MEM_LAT=1.
- Reset, then press at cursor=4, then press at cursor=5 -> val1=val2=2. match_pulse for 1 cycle, matched[4]=matched[5]=1, pair_count=1, state back to PICK1.
- Press 0, then press 2 -> mismatch_pulse. face_up[0] and face_up[2] stay 1 for exactly 8 cycles, then both clear; matched stays 0.
- Invalid presses, each ignored with no change to state, face_up, or mem_raddr:
  - cursor=40
  - cursor=4 after {4,5} are matched
  - cursor=sel1 in PICK2
  - any press during READ1, COMPARE, or HOLD
- Match all 18 pairs in order -> pair_count=18 and game_over=1 on the cycle after the last COMPARE. Further presses do nothing.
- Hold reset_n=0 for one edge during HOLD (cycle 3 of 8) -> all outputs 0 on the next cycle. A new press at cursor=7 is accepted from PICK1.
- Sweep MEM_LAT=2 -> val1 is captured on the 3rd edge after the accept edge and the compare result is unchanged.
